script_sequencer: RTL

Sequences the 16-bit game-script program held in a synchronous script ROM. It fetches each instruction at the byte-addressed pc and decodes the fields i_num[15:8], i_sign[7:5], fun[4:3] and op_code[2:0]. It then issues actions to the output path over a valid/ready handshake, and executes jumps, waits and game-state updates. It sits between the script ROM and the action/UART output stage, under control of the game top level.

---
 rtl/script_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/script_sequencer.sv
// Game-script sequencer: fetches 16-bit instructions from a synchronous ROM, issues actions
// over valid/ready and runs jumps, timed/conditional waits and game-state updates. Optional macro: SCRIPT_STEP_EN.
module script_sequencer #(
    parameter int PC_W     = 8,
    parameter int TICK_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
`ifdef SCRIPT_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    output logic [7:0]      act_data,
    output logic [1:0]      act_kind,
    output logic            act_valid,
    input  logic            act_ready,
    input  logic [7:0]      feedback,
    output logic [7:0]      game_state,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ACT,
        S_WAIT_T,
        S_WAIT_C,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0]      OP_ACT    = 3'b001;
    localparam logic [2:0]      OP_JMP    = 3'b010;
    localparam logic [2:0]      OP_WAIT   = 3'b011;
    localparam logic [2:0]      OP_GAME   = 3'b100;
    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PC_W-1:0] PC_LAST   = {{(PC_W-1){1'b1}}, 1'b0};

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_act_data;
    logic [1:0]      r_act_kind;
    logic            r_act_valid;
    logic [7:0]      r_game_state;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [2:0]      r_sign;
    logic [TW-1:0]   r_tick;
    logic [7:0]      r_wait;

    logic [7:0]      w_i_num;
    logic [2:0]      w_i_sign;
    logic [1:0]      w_fun;
    logic [2:0]      w_op;
    logic            w_pc_last;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_jump_target;
    logic            w_jump_cond;
    logic            w_wait_cond;
    logic            w_fetch_go;

    assign w_i_num       = rom_data[15:8];
    assign w_i_sign      = rom_data[7:5];
    assign w_fun         = rom_data[4:3];
    assign w_op          = rom_data[2:0];
    assign w_pc_last     = (r_pc == PC_LAST);
    assign w_pc_inc      = r_pc + PC_W'(2);
    assign w_jump_target = PC_W'({w_i_num[7:1], 1'b0});
    assign w_jump_cond   = feedback[w_i_sign];
    assign w_wait_cond   = feedback[r_sign];

`ifdef SCRIPT_STEP_EN
    assign w_fetch_go = step;
`else
    assign w_fetch_go = 1'b1;
`endif

    // Every "pc+2" path refuses to wrap: at the last even address it traps into ERR with pc held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_act_data   <= '0;
            r_act_kind   <= '0;
            r_act_valid  <= 1'b0;
            r_game_state <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_sign       <= '0;
            r_tick       <= '0;
            r_wait       <= '0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_act_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tick      <= '0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w_fetch_go) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_sign <= w_i_sign;
                    case (w_op)
                        OP_ACT: begin
                            r_act_data  <= w_i_num;
                            r_act_kind  <= w_fun;
                            r_act_valid <= 1'b1;
                            r_state     <= S_ACT;
                        end
                        OP_JMP: begin
                            if (w_fun == 2'b00 || (w_fun == 2'b01 && w_jump_cond)) begin
                                r_pc    <= w_jump_target;
                                r_state <= S_FETCH;
                            end else if (w_pc_last) begin
                                r_state <= S_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_FETCH;
                            end
                        end
                        OP_WAIT: begin
                            if (w_fun == 2'b00 && w_i_num != 8'd0) begin
                                r_wait  <= w_i_num;
                                r_tick  <= '0;
                                r_state <= S_WAIT_T;
                            end else if (w_fun == 2'b01) begin
                                r_state <= S_WAIT_C;
                            end else if (w_pc_last) begin
                                r_state <= S_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_FETCH;
                            end
                        end
                        OP_GAME: begin
                            if (w_fun == 2'b00) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                if (w_fun == 2'b01) begin
                                    r_game_state <= w_i_num;
                                end
                                if (w_pc_last) begin
                                    r_state <= S_ERR;
                                    r_busy  <= 1'b0;
                                    r_err   <= 1'b1;
                                end else begin
                                    r_pc    <= w_pc_inc;
                                    r_state <= S_FETCH;
                                end
                            end
                        end
                        default: begin
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    endcase
                end
                S_ACT: begin
                    if (act_ready) begin
                        r_act_valid <= 1'b0;
                        if (w_pc_last) begin
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WAIT_T: begin
                    // r_wait counts remaining ticks; the last tick's final cycle leaves the state.
                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (r_wait == 8'd1) begin
                            r_wait <= '0;
                            if (w_pc_last) begin
                                r_state <= S_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_wait <= r_wait - 8'd1;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_WAIT_C: begin
                    if (w_wait_cond) begin
                        if (w_pc_last) begin
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    end
                end
            endcase
        end
    end

    assign rom_addr   = r_pc;
    assign pc         = r_pc;
    assign act_data   = r_act_data;
    assign act_kind   = r_act_kind;
    assign act_valid  = r_act_valid;
    assign game_state = r_game_state;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
